// File: rtl/tt_pkg.sv
// tt_pkg: shared state encoding and sizing helper for the truth-table checker
package tt_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int pow2(input int n);
        return 1 << n;
    endfunction
endpackage

// File: rtl/truth_table_checker_if.sv
// truth_table_checker_if: start/stimulus/result bundle between the checker and its user
interface truth_table_checker_if #(parameter int N_INPUTS = 2);
    logic                start;
    logic [N_INPUTS-1:0] stim;
    logic                dut_result;
    logic                busy;
    logic                done;
    logic                pass;
    logic [N_INPUTS:0]   mismatch_count;
    logic                first_fail_valid;
    logic [N_INPUTS-1:0] first_fail_idx;

    modport master (
        input  start, dut_result,
        output stim, busy, done, pass, mismatch_count, first_fail_valid, first_fail_idx
    );

    modport slave (
        output start, dut_result,
        input  stim, busy, done, pass, mismatch_count, first_fail_valid, first_fail_idx
    );
endinterface

// File: rtl/settle_timer.sv
// settle_timer: loadable down-counter that flags zero to end a settle window
module settle_timer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= 8'(SETTLE_CYCLES - 1);
        else if (dec && cnt != '0)
            cnt <= cnt - 8'd1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps every input vector of a small combinational DUT and checks it against EXPECTED
module truth_table_checker
    import tt_pkg::*;
#(
    parameter int                          N_INPUTS      = 2,
    parameter int                          SETTLE_CYCLES = 1,
    parameter logic [pow2(N_INPUTS)-1:0]   EXPECTED      = 4'b1000
) (
    input logic                   clk,
    input logic                   rst_n,
    truth_table_checker_if.master bus
);
    localparam int                NV   = pow2(N_INPUTS);
    localparam logic [N_INPUTS:0] LAST = (N_INPUTS+1)'(NV - 1);

    state_t            state;
    logic [N_INPUTS:0] idx;
    logic              load, zero, miss;

    assign load = (state == IDLE && bus.start) || (state == SAMPLE && idx != LAST);
    // Case-inequality so an X/Z response is a failure rather than a silent pass
    assign miss = bus.dut_result !== EXPECTED[idx[N_INPUTS-1:0]];

    settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .dec  (state == SETTLE),
        .zero (zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            idx                  <= '0;
            bus.stim             <= '0;
            bus.busy             <= 1'b0;
            bus.done             <= 1'b0;
            bus.pass             <= 1'b0;
            bus.mismatch_count   <= '0;
            bus.first_fail_valid <= 1'b0;
            bus.first_fail_idx   <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    bus.mismatch_count   <= '0;
                    bus.first_fail_valid <= 1'b0;
                    bus.first_fail_idx   <= '0;
                    bus.pass             <= 1'b0;
                    bus.stim             <= '0;
                    bus.busy             <= 1'b1;
                    idx                  <= '0;
                    state                <= SETTLE;
                end
                SETTLE: if (zero) state <= SAMPLE;
                SAMPLE: begin
                    if (miss) begin
                        bus.mismatch_count <= bus.mismatch_count + 1'b1;
                        if (!bus.first_fail_valid) begin
                            bus.first_fail_valid <= 1'b1;
                            bus.first_fail_idx   <= idx[N_INPUTS-1:0];
                        end
                    end
                    if (idx == LAST) begin
                        state <= DONE;
                    end else begin
                        idx      <= idx + 1'b1;
                        bus.stim <= bus.stim + 1'b1;
                        state    <= SETTLE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    bus.pass <= (bus.mismatch_count == '0);
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: directed-vector bench for the truth-table checker
module tb_truth_table_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   mode = 0;
    logic xv = 1'bx;
    int   lat, ndone;
    logic busy0;
    logic [1:0] hist_a [0:15];
    logic [2:0] hist_b [0:63];

    always #5 clk = ~clk;

    truth_table_checker_if #(.N_INPUTS(2)) ia ();
    truth_table_checker_if #(.N_INPUTS(3)) ib ();

    assign ia.dut_result = (mode == 1) ? (ia.stim[0] | ia.stim[1]) :
                           (mode == 2 && ia.stim == 2'd2) ? xv : (ia.stim[0] & ia.stim[1]);
    assign ib.dut_result = ib.stim[0] ^ ib.stim[1] ^ ib.stim[2];

    truth_table_checker #(.N_INPUTS(2), .SETTLE_CYCLES(1), .EXPECTED(4'b1000)) ua (
        .clk(clk), .rst_n(rst_n), .bus(ia)
    );
    truth_table_checker #(.N_INPUTS(3), .SETTLE_CYCLES(3), .EXPECTED(8'b1001_0110)) ub (
        .clk(clk), .rst_n(rst_n), .bus(ib)
    );

    task automatic sweep_a(input int poke);
        ndone = 0;
        @(negedge clk) ia.start = 1'b1;
        @(posedge clk); #1 ia.start = 1'b0;
        lat = 0;
        hist_a[0] = ia.stim;
        busy0 = ia.busy;
        while (ia.done !== 1'b1 && lat < 100) begin
            ia.start = (lat == poke - 1);
            @(posedge clk); #1 lat++;
            if (lat < 16) hist_a[lat] = ia.stim;
        end
        ia.start = 1'b0;
        if (ia.done === 1'b1) ndone++;
        repeat (12) begin
            @(posedge clk); #1 if (ia.done === 1'b1) ndone++;
        end
    endtask

    task automatic sweep_b();
        @(negedge clk) ib.start = 1'b1;
        @(posedge clk); #1 ib.start = 1'b0;
        lat = 0;
        hist_b[0] = ib.stim;
        while (ib.done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1 lat++;
            if (lat < 64) hist_b[lat] = ib.stim;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (ia.stim !== 2'd0) begin errors++; $display("FAIL reset_stim got %0d want 0", ia.stim); end
        checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", ia.busy); end
        checks++; if (ia.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", ia.done); end
        checks++; if (ia.pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", ia.pass); end
        checks++; if (ia.mismatch_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", ia.mismatch_count); end
        checks++; if (ia.first_fail_valid !== 1'b0) begin errors++; $display("FAIL reset_ffv got %b want 0", ia.first_fail_valid); end
        checks++; if (ia.first_fail_idx !== 2'd0) begin errors++; $display("FAIL reset_ffidx got %0d want 0", ia.first_fail_idx); end
        checks++; if (ib.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_b got %b want 0", ib.busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_and();
        mode = 0;
        sweep_a(-5);
        checks++; if (lat !== 9) begin errors++; $display("FAIL and_latency got %0d want 9", lat); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL and_busy_start got %b want 1", busy0); end
        checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL and_busy_end got %b want 0", ia.busy); end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL and_done_pulses got %0d want 1", ndone); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (hist_a[k] !== 2'(k / 2)) begin errors++; $display("FAIL and_stim_%0d got %0d want %0d", k, hist_a[k], k / 2); end
        end
        checks++; if (hist_a[9] !== 2'd3) begin errors++; $display("FAIL and_stim_hold got %0d want 3", hist_a[9]); end
        checks++; if (ia.pass !== 1'b1) begin errors++; $display("FAIL and_pass got %b want 1", ia.pass); end
        checks++; if (ia.mismatch_count !== 3'd0) begin errors++; $display("FAIL and_count got %0d want 0", ia.mismatch_count); end
        checks++; if (ia.first_fail_valid !== 1'b0) begin errors++; $display("FAIL and_ffv got %b want 0", ia.first_fail_valid); end
        checks++; if (ia.stim !== 2'd3) begin errors++; $display("FAIL and_stim_idle got %0d want 3", ia.stim); end
    endtask

    task automatic test_or();
        mode = 1;
        sweep_a(-5);
        checks++; if (lat !== 9) begin errors++; $display("FAIL or_latency got %0d want 9", lat); end
        checks++; if (ia.pass !== 1'b0) begin errors++; $display("FAIL or_pass got %b want 0", ia.pass); end
        checks++; if (ia.mismatch_count !== 3'd2) begin errors++; $display("FAIL or_count got %0d want 2", ia.mismatch_count); end
        checks++; if (ia.first_fail_valid !== 1'b1) begin errors++; $display("FAIL or_ffv got %b want 1", ia.first_fail_valid); end
        checks++; if (ia.first_fail_idx !== 2'd1) begin errors++; $display("FAIL or_ffidx got %0d want 1", ia.first_fail_idx); end
    endtask

    task automatic test_reset_mid();
        mode = 0;
        @(negedge clk) ia.start = 1'b1;
        @(posedge clk); #1 ia.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (ia.stim !== 2'd0) begin errors++; $display("FAIL rstmid_stim got %0d want 0", ia.stim); end
        checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", ia.busy); end
        checks++; if (ia.mismatch_count !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", ia.mismatch_count); end
        checks++; if (ia.first_fail_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ffv got %b want 0", ia.first_fail_valid); end
        checks++; if (ia.first_fail_idx !== 2'd0) begin errors++; $display("FAIL rstmid_ffidx got %0d want 0", ia.first_fail_idx); end
        ndone = 0;
        repeat (6) begin
            @(posedge clk); #1 if (ia.done === 1'b1) ndone++;
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1 if (ia.done === 1'b1) ndone++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d want 0", ndone); end
        sweep_a(-5);
        checks++; if (lat !== 9) begin errors++; $display("FAIL rstmid_restart_latency got %0d want 9", lat); end
        checks++; if (ia.pass !== 1'b1) begin errors++; $display("FAIL rstmid_restart_pass got %b want 1", ia.pass); end
    endtask

    task automatic test_ignore_start();
        mode = 1;
        sweep_a(4);
        checks++; if (lat !== 9) begin errors++; $display("FAIL ign_latency got %0d want 9", lat); end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL ign_done_pulses got %0d want 1", ndone); end
        checks++; if (hist_a[5] !== 2'd2) begin errors++; $display("FAIL ign_stim5 got %0d want 2", hist_a[5]); end
        checks++; if (ia.mismatch_count !== 3'd2) begin errors++; $display("FAIL ign_count got %0d want 2", ia.mismatch_count); end
        checks++; if (ia.first_fail_idx !== 2'd1) begin errors++; $display("FAIL ign_ffidx got %0d want 1", ia.first_fail_idx); end
        checks++; if (ia.pass !== 1'b0) begin errors++; $display("FAIL ign_pass got %b want 0", ia.pass); end
    endtask

    task automatic test_x_result();
        logic xmiss;
        mode = 2;
        xmiss = (xv !== 1'b0);
        sweep_a(-5);
        checks++; if (ia.mismatch_count !== (xmiss ? 3'd1 : 3'd0)) begin errors++; $display("FAIL x_count got %0d want %0d", ia.mismatch_count, xmiss); end
        checks++; if (ia.pass !== !xmiss) begin errors++; $display("FAIL x_pass got %b want %b", ia.pass, !xmiss); end
        checks++; if (ia.first_fail_valid !== xmiss) begin errors++; $display("FAIL x_ffv got %b want %b", ia.first_fail_valid, xmiss); end
        if (xmiss) begin
            checks++; if (ia.first_fail_idx !== 2'd2) begin errors++; $display("FAIL x_ffidx got %0d want 2", ia.first_fail_idx); end
        end
    endtask

    task automatic test_xor3();
        sweep_b();
        checks++; if (lat !== 33) begin errors++; $display("FAIL xor3_latency got %0d want 33", lat); end
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (hist_b[k] !== 3'(k / 4)) begin errors++; $display("FAIL xor3_stim_%0d got %0d want %0d", k, hist_b[k], k / 4); end
        end
        checks++; if (ib.pass !== 1'b1) begin errors++; $display("FAIL xor3_pass got %b want 1", ib.pass); end
        checks++; if (ib.mismatch_count !== 4'd0) begin errors++; $display("FAIL xor3_count got %0d want 0", ib.mismatch_count); end
        checks++; if (ib.busy !== 1'b0) begin errors++; $display("FAIL xor3_busy got %b want 0", ib.busy); end
    endtask

    initial begin
        ia.start = 1'b0;
        ib.start = 1'b0;
        test_reset();
        test_and();
        test_or();
        test_reset_mid();
        test_ignore_start();
        test_x_result();
        test_xor3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
